// File: rtl/code_lock_ctrl.sv
// Keypad code lock: buffers CODE_LEN digits, checks against a stored code, unlocks or counts failures into a timed lockout.
// Latency: last digit strobe at t, result visible at t+2; no backpressure, keys outside IDLE/ENTRY/UNLOCKED are dropped.
module code_lock_ctrl #(
  parameter int CODE_LEN    = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 12000000,
  parameter int LOCKOUT_CYC = 120000000,
  parameter int BLINK_HALF  = 6000000,
  parameter logic [DIGIT_W-1:0]          RELOCK_KEY = 4'hF,
  parameter logic [CODE_LEN*DIGIT_W-1:0] RESET_CODE = 16'h4321
) (
  input  logic                                hwclk,
  input  logic                                rst_n,
  input  logic                                key_valid,
  input  logic [DIGIT_W-1:0]                  key_digit,
  input  logic                                code_wr,
  input  logic [CODE_LEN*DIGIT_W-1:0]         code_in,
  output logic                                unlocked,
  output logic                                fail_pulse,
  output logic                                locked_out,
  output logic                                blink_led,
  output logic [$clog2(CODE_LEN+1)-1:0]       digit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]      tries_left
);

  localparam int CODE_W  = CODE_LEN * DIGIT_W;
  localparam int DC_W    = $clog2(CODE_LEN + 1);
  localparam int TR_W    = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int BL_W    = $clog2(BLINK_HALF + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_FAIL, S_LOCKOUT
  } state_t;

  state_t              state;
  logic [CODE_W-1:0]   code_reg;
  logic [CODE_W-1:0]   code_buf;
  logic [TMR_W-1:0]    tmr;
  logic [BL_W-1:0]     blink_cnt;
  logic [CODE_W-1:0]   buf_shift;
  logic                key_is_relock;

  // Digits shift in from the top, so after CODE_LEN keys the first one sits at index 0.
  assign buf_shift     = {key_digit, code_buf[CODE_W-1:DIGIT_W]};
  assign key_is_relock = (key_digit == RELOCK_KEY);

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      code_reg    <= RESET_CODE;
      code_buf    <= '0;
      tmr         <= '0;
      blink_cnt   <= '0;
      unlocked    <= 1'b0;
      fail_pulse  <= 1'b0;
      locked_out  <= 1'b0;
      blink_led   <= 1'b0;
      digit_count <= '0;
      tries_left  <= TR_W'(MAX_TRIES);
    end else begin
      fail_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_valid && !key_is_relock) begin
            code_buf    <= buf_shift;
            digit_count <= DC_W'(1);
            tmr         <= '0;
            state       <= S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (key_valid) begin
            if (key_is_relock) begin
              code_buf    <= '0;
              digit_count <= '0;
              state       <= S_IDLE;
            end else begin
              code_buf    <= buf_shift;
              digit_count <= digit_count + 1'b1;
              tmr         <= '0;
              if (digit_count == DC_W'(CODE_LEN - 1)) state <= S_CHECK;
            end
          end else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
            code_buf    <= '0;
            digit_count <= '0;
            state       <= S_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_CHECK: begin
          digit_count <= '0;
          code_buf    <= '0;
          tmr         <= '0;
          blink_cnt   <= '0;
          blink_led   <= 1'b1;
          if (code_buf == code_reg) begin
            unlocked   <= 1'b1;
            tries_left <= TR_W'(MAX_TRIES);
            state      <= S_UNLOCKED;
          end else if (tries_left > TR_W'(1)) begin
            tries_left <= tries_left - 1'b1;
            fail_pulse <= 1'b1;
            state      <= S_FAIL;
          end else begin
            tries_left <= '0;
            locked_out <= 1'b1;
            state      <= S_LOCKOUT;
          end
        end
        S_UNLOCKED: begin
          if (code_wr) code_reg <= code_in;
          if ((key_valid && key_is_relock) ||
              (!key_valid && tmr == TMR_W'(TIMEOUT_CYC - 1))) begin
            unlocked  <= 1'b0;
            blink_led <= 1'b0;
            state     <= S_IDLE;
          end else if (key_valid) begin
            tmr <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_FAIL: begin
          // One lit half-period, one dark half-period, then back to IDLE.
          if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            if (blink_led) blink_led <= 1'b0;
            else           state     <= S_IDLE;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (tmr == TMR_W'(LOCKOUT_CYC - 1)) begin
            tries_left <= TR_W'(MAX_TRIES);
            locked_out <= 1'b0;
            blink_led  <= 1'b0;
            blink_cnt  <= '0;
            state      <= S_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
            if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
              blink_cnt <= '0;
              blink_led <= ~blink_led;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: vector table plus hand sequences, expectations queued per driven cycle.
module tb_code_lock_ctrl;

  logic        hwclk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        code_wr;
  logic [15:0] code_in;
  logic        unlocked, fail_pulse, locked_out, blink_led;
  logic [2:0]  digit_count;
  logic [1:0]  tries_left;

  code_lock_ctrl #(
    .CODE_LEN(4), .DIGIT_W(4), .MAX_TRIES(3), .TIMEOUT_CYC(20),
    .LOCKOUT_CYC(50), .BLINK_HALF(4), .RELOCK_KEY(4'hF), .RESET_CODE(16'h4321)
  ) dut (
    .hwclk(hwclk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .code_wr(code_wr), .code_in(code_in), .unlocked(unlocked), .fail_pulse(fail_pulse),
    .locked_out(locked_out), .blink_led(blink_led), .digit_count(digit_count),
    .tries_left(tries_left)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  typedef struct {
    logic        kv;
    logic [3:0]  dig;
    logic        wr;
    logic [15:0] cin;
    logic [8:0]  exp;
  } vec_t;

  vec_t        vecs[$];
  logic [8:0]  exp_q[$];
  string       nm_q[$];
  int          n_run  = 0;
  int          n_fail = 0;

  // {unlocked, fail_pulse, locked_out, blink_led, digit_count[2:0], tries_left[1:0]}
  function automatic logic [8:0] pk(input bit unl, input bit fp, input bit lo, input bit bl,
                                    input int dc, input int tr);
    return {unl, fp, lo, bl, 3'(dc), 2'(tr)};
  endfunction

  function automatic vec_t v(input bit kv, input int dig, input bit wr, input int cin,
                             input logic [8:0] exp);
    vec_t r;
    r.kv = kv; r.dig = 4'(dig); r.wr = wr; r.cin = 16'(cin); r.exp = exp;
    return r;
  endfunction

  task automatic compare(input logic [8:0] exp, input string nm);
    logic [8:0] act;
    act = {unlocked, fail_pulse, locked_out, blink_led, digit_count, tries_left};
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (unl,fp,lo,bl,dc[3],tries[2])", nm, act, exp);
    end
  endtask

  task automatic step(input logic kv, input logic [3:0] dig, input logic wr,
                      input logic [15:0] cin, input logic [8:0] exp, input string nm);
    key_valid = kv; key_digit = dig; code_wr = wr; code_in = cin;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    @(posedge hwclk);
    #1;
    key_valid = 1'b0; code_wr = 1'b0; code_in = '0;
    compare(exp_q.pop_front(), nm_q.pop_front());
  endtask

  task automatic keys4(input logic [15:0] code, input int tr, input string nm);
    for (int i = 0; i < 4; i++)
      step(1'b1, code[i*4 +: 4], 1'b0, '0, pk(0, 0, 0, 0, i + 1, tr), nm);
  endtask

  task automatic fail_wait(input int tr);
    for (int i = 1; i <= 8; i++)
      step(1'b0, 4'h0, 1'b0, '0, pk(0, 0, 0, i < 4, 0, tr), "fail_blink");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Unlock/relock, code write ignored outside UNLOCKED, code change, FAIL blink window.
    vecs.push_back(v(1, 1, 0, 0, pk(0, 0, 0, 0, 1, 3)));
    vecs.push_back(v(1, 2, 0, 0, pk(0, 0, 0, 0, 2, 3)));
    vecs.push_back(v(1, 3, 0, 0, pk(0, 0, 0, 0, 3, 3)));
    vecs.push_back(v(1, 4, 0, 0, pk(0, 0, 0, 0, 4, 3)));
    vecs.push_back(v(0, 0, 0, 0, pk(1, 0, 0, 1, 0, 3)));
    vecs.push_back(v(1, 7, 0, 0, pk(1, 0, 0, 1, 0, 3)));
    vecs.push_back(v(1, 15, 0, 0, pk(0, 0, 0, 0, 0, 3)));
    vecs.push_back(v(1, 15, 0, 0, pk(0, 0, 0, 0, 0, 3)));
    vecs.push_back(v(0, 0, 1, 16'h1111, pk(0, 0, 0, 0, 0, 3)));
    vecs.push_back(v(1, 1, 0, 0, pk(0, 0, 0, 0, 1, 3)));
    vecs.push_back(v(1, 2, 0, 0, pk(0, 0, 0, 0, 2, 3)));
    vecs.push_back(v(1, 3, 0, 0, pk(0, 0, 0, 0, 3, 3)));
    vecs.push_back(v(1, 4, 0, 0, pk(0, 0, 0, 0, 4, 3)));
    vecs.push_back(v(0, 0, 0, 0, pk(1, 0, 0, 1, 0, 3)));
    vecs.push_back(v(0, 0, 1, 16'h9876, pk(1, 0, 0, 1, 0, 3)));
    vecs.push_back(v(1, 15, 0, 0, pk(0, 0, 0, 0, 0, 3)));
    vecs.push_back(v(1, 1, 0, 0, pk(0, 0, 0, 0, 1, 3)));
    vecs.push_back(v(1, 2, 0, 0, pk(0, 0, 0, 0, 2, 3)));
    vecs.push_back(v(1, 3, 0, 0, pk(0, 0, 0, 0, 3, 3)));
    vecs.push_back(v(1, 4, 0, 0, pk(0, 0, 0, 0, 4, 3)));
    vecs.push_back(v(0, 0, 0, 0, pk(0, 1, 0, 1, 0, 2)));
    vecs.push_back(v(0, 0, 0, 0, pk(0, 0, 0, 1, 0, 2)));
    vecs.push_back(v(0, 0, 0, 0, pk(0, 0, 0, 1, 0, 2)));
    vecs.push_back(v(0, 0, 0, 0, pk(0, 0, 0, 1, 0, 2)));
    vecs.push_back(v(0, 0, 0, 0, pk(0, 0, 0, 0, 0, 2)));
    vecs.push_back(v(1, 5, 0, 0, pk(0, 0, 0, 0, 0, 2)));
    vecs.push_back(v(0, 0, 0, 0, pk(0, 0, 0, 0, 0, 2)));
    vecs.push_back(v(0, 0, 0, 0, pk(0, 0, 0, 0, 0, 2)));
    vecs.push_back(v(0, 0, 0, 0, pk(0, 0, 0, 0, 0, 2)));
    vecs.push_back(v(1, 6, 0, 0, pk(0, 0, 0, 0, 1, 2)));
    vecs.push_back(v(1, 7, 0, 0, pk(0, 0, 0, 0, 2, 2)));
    vecs.push_back(v(1, 8, 0, 0, pk(0, 0, 0, 0, 3, 2)));
    vecs.push_back(v(1, 9, 0, 0, pk(0, 0, 0, 0, 4, 2)));
    vecs.push_back(v(0, 0, 0, 0, pk(1, 0, 0, 1, 0, 3)));
    vecs.push_back(v(1, 15, 0, 0, pk(0, 0, 0, 0, 0, 3)));

    key_valid = 1'b0; key_digit = '0; code_wr = 1'b0; code_in = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 compare(pk(0, 0, 0, 0, 0, 3), "reset_state");
    repeat (2) @(posedge hwclk);
    @(negedge hwclk) rst_n = 1'b1;

    foreach (vecs[i])
      step(vecs[i].kv, vecs[i].dig, vecs[i].wr, vecs[i].cin, vecs[i].exp, $sformatf("vec[%0d]", i));

    // Three wrong codes against 9876: two FAILs then LOCKOUT.
    keys4(16'h5321, 3, "att1");
    step(1'b0, 4'h0, 1'b0, '0, pk(0, 1, 0, 1, 0, 2), "fail1");
    fail_wait(2);
    keys4(16'h5321, 2, "att2");
    step(1'b0, 4'h0, 1'b0, '0, pk(0, 1, 0, 1, 0, 1), "fail2");
    fail_wait(1);
    keys4(16'h5321, 1, "att3");
    step(1'b0, 4'h0, 1'b0, '0, pk(0, 0, 1, 1, 0, 0), "lockout_entry");
    for (int i = 1; i <= 50; i++)
      step((i % 7) == 3, 4'h1, 1'b0, '0,
           (i < 50) ? pk(0, 0, 1, ((i / 4) % 2) == 0, 0, 0) : pk(0, 0, 0, 0, 0, 3),
           $sformatf("lockout[%0d]", i));

    // Write a new code, then get locked out and reset mid-lockout.
    keys4(16'h9876, 3, "unlock_9876");
    step(1'b0, 4'h0, 1'b0, '0, pk(1, 0, 0, 1, 0, 3), "unlocked_9876");
    step(1'b0, 4'h0, 1'b1, 16'h5555, pk(1, 0, 0, 1, 0, 3), "code_wr_5555");
    step(1'b1, 4'hF, 1'b0, '0, pk(0, 0, 0, 0, 0, 3), "relock");
    keys4(16'h4321, 3, "old_code1");
    step(1'b0, 4'h0, 1'b0, '0, pk(0, 1, 0, 1, 0, 2), "old_fail1");
    fail_wait(2);
    keys4(16'h4321, 2, "old_code2");
    step(1'b0, 4'h0, 1'b0, '0, pk(0, 1, 0, 1, 0, 1), "old_fail2");
    fail_wait(1);
    keys4(16'h4321, 1, "old_code3");
    step(1'b0, 4'h0, 1'b0, '0, pk(0, 0, 1, 1, 0, 0), "lockout2_entry");
    for (int i = 1; i <= 6; i++)
      step(1'b0, 4'h0, 1'b0, '0, pk(0, 0, 1, ((i / 4) % 2) == 0, 0, 0), "lockout2");
    #2 rst_n = 1'b0;
    #1 compare(pk(0, 0, 0, 0, 0, 3), "reset_async");
    @(negedge hwclk) rst_n = 1'b1;
    keys4(16'h4321, 3, "reset_code");
    step(1'b0, 4'h0, 1'b0, '0, pk(1, 0, 0, 1, 0, 3), "reset_code_unlock");

    // Auto-relock; a non-relock key restarts the idle timer.
    for (int i = 1; i <= 30; i++)
      step(i == 10, 4'h7, 1'b0, '0, pk(i < 30, 0, 0, i < 30, 0, 3), $sformatf("auto_relock[%0d]", i));

    // Entry timeout, and a key on the expiry cycle wins.
    step(1'b1, 4'h1, 1'b0, '0, pk(0, 0, 0, 0, 1, 3), "to_k1");
    step(1'b1, 4'h2, 1'b0, '0, pk(0, 0, 0, 0, 2, 3), "to_k2");
    for (int i = 1; i <= 20; i++)
      step(1'b0, 4'h0, 1'b0, '0, pk(0, 0, 0, 0, (i < 20) ? 2 : 0, 3), $sformatf("timeout[%0d]", i));
    step(1'b1, 4'h1, 1'b0, '0, pk(0, 0, 0, 0, 1, 3), "exp_k1");
    step(1'b1, 4'h2, 1'b0, '0, pk(0, 0, 0, 0, 2, 3), "exp_k2");
    for (int i = 1; i <= 19; i++)
      step(1'b0, 4'h0, 1'b0, '0, pk(0, 0, 0, 0, 2, 3), "pre_expiry");
    step(1'b1, 4'h3, 1'b0, '0, pk(0, 0, 0, 0, 3, 3), "expiry_key");
    step(1'b1, 4'hF, 1'b0, '0, pk(0, 0, 0, 0, 0, 3), "cancel_entry");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
